// File: rtl/range_stream_source.sv
// range_stream_source: BIST / testbench source for the range-finder sample protocol.
// On start it emits a burst of n = max(length,2) samples framed by go (first sample)
// and finish (last sample), tracks min/max of what it sent, then compares range_in.
// Optional build macro: RSS_RAMP_MODE_EN (samples count up by one instead of LFSR).
// Ports:
//   clock, reset            : single clock, asynchronous active-high reset
//   start, length, seed     : burst request, sampled only while idle
//   range_in, error_in      : finder result and finder debug error, sampled in CHECK
//   data_out, go, finish    : registered sample stream and framing
//   busy, done, mismatch    : status; done pulses one cycle with mismatch valid
//   exp_range               : self-computed max-min, held until the next check
module range_stream_source #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'h240
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       length,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] range_in,
  input  logic             error_in,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [WIDTH-1:0] exp_range
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_STREAM,
    S_LAST,
    S_CHECK
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             go_q, go_d;
  logic             finish_q, finish_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;
  logic [WIDTH-1:0] exp_range_q, exp_range_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [7:0]       cnt_q, cnt_d;   // samples emitted so far; reaches at most 255
  logic [7:0]       n_q, n_d;       // burst length, already clamped to >= 2

  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] next_sample;
  logic [WIDTH-1:0] cur_range;

`ifdef RSS_RAMP_MODE_EN
  assign seed_eff    = seed;
  assign next_sample = data_q + WIDTH'(1);
`else
  // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
  assign seed_eff    = (seed == '0) ? WIDTH'(1) : seed;
  assign next_sample = {data_q[WIDTH-2:0], ^(data_q & TAPS)};
`endif

  // max >= min always holds once the first sample is loaded, so no wrap.
  assign cur_range = max_q - min_q;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    go_d        = 1'b0;
    finish_d    = 1'b0;
    done_d      = 1'b0;
    mismatch_d  = mismatch_q;
    exp_range_d = exp_range_q;
    min_d       = min_q;
    max_d       = max_q;
    cnt_d       = cnt_q;
    n_d         = n_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d        = (length < 8'd2) ? 8'd2 : length;
          data_d     = seed_eff;
          min_d      = seed_eff;
          max_d      = seed_eff;
          cnt_d      = 8'd1;
          go_d       = 1'b1;
          mismatch_d = 1'b0;
          state_d    = S_FIRST;
        end
      end
      S_FIRST, S_STREAM: begin
        data_d = next_sample;
        cnt_d  = cnt_q + 8'd1;
        if (next_sample < min_q) min_d = next_sample;
        if (next_sample > max_q) max_d = next_sample;
        // cnt_q is the index of the sample being loaded now; index n-1 is the last.
        if (cnt_q == n_q - 8'd1) begin
          finish_d = 1'b1;
          state_d  = S_LAST;
        end else begin
          state_d  = S_STREAM;
        end
      end
      S_LAST: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        exp_range_d = cur_range;
        mismatch_d  = (range_in != cur_range) | error_in;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      go_q        <= 1'b0;
      finish_q    <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      exp_range_q <= '0;
      min_q       <= '0;
      max_q       <= '0;
      cnt_q       <= 8'd0;
      n_q         <= 8'd2;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      go_q        <= go_d;
      finish_q    <= finish_d;
      done_q      <= done_d;
      mismatch_q  <= mismatch_d;
      exp_range_q <= exp_range_d;
      min_q       <= min_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
    end
  end

  assign data_out  = data_q;
  assign go        = go_q;
  assign finish    = finish_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign mismatch  = mismatch_q;
  assign exp_range = exp_range_q;

endmodule

// File: tb/tb_range_stream_source.sv
module tb_range_stream_source;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] length;
  logic [9:0] seed;
  logic [9:0] range_in;
  logic       error_in;
  logic [9:0] data_out;
  logic       go;
  logic       finish;
  logic       busy;
  logic       done;
  logic       mismatch;
  logic [9:0] exp_range;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];

  range_stream_source dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .length   (length),
    .seed     (seed),
    .range_in (range_in),
    .error_in (error_in),
    .data_out (data_out),
    .go       (go),
    .finish   (finish),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch),
    .exp_range(exp_range)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference sample step, written from the protocol description.
  function automatic logic [9:0] model_step(input logic [9:0] c);
`ifdef RSS_RAMP_MODE_EN
    return c + 10'd1;
`else
    logic [9:0] masked;
    masked = c & 10'h240;
    return {c[8:0], masked[9] ^ masked[6]};
`endif
  endfunction

  // Pushes the expected sample sequence into the scoreboard, returns max-min.
  function automatic logic [9:0] model_burst(input logic [9:0] sd, input logic [7:0] len);
    logic [9:0] cur, mn, mx;
    int n;
    n = (len < 8'd2) ? 2 : int'(len);
    cur = sd;
`ifndef RSS_RAMP_MODE_EN
    if (cur == 10'd0) cur = 10'd1;
`endif
    mn = cur;
    mx = cur;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(cur);
      if (cur < mn) mn = cur;
      if (cur > mx) mx = cur;
      cur = model_step(cur);
    end
    return mx - mn;
  endfunction

  // Drives one burst and records what the DUT produced; returns in the done cycle
  // (#1 after the edge), so a following call asserts start in that very cycle.
  task automatic drive_burst(input logic [9:0] sd, input logic [7:0] len,
                             input logic [9:0] rng, input logic err, input bit poke,
                             output int go_cyc, output int fin_cyc, output int done_cyc,
                             output logic mm, output logic [9:0] er,
                             output bit overlap, output logic mm_at_go, output bit tmo);
    bit in_b;
    int k;
    go_cyc = -1; fin_cyc = -1; done_cyc = -1; mm = 1'b0; er = '0;
    overlap = 0; mm_at_go = 1'bx; tmo = 0; in_b = 0; k = 0;
    obs_q.delete();
    start = 1'b1; length = len; seed = sd; range_in = rng; error_in = err;
    while (done_cyc < 0 && !tmo) begin
      @(posedge clock); #1;
      k++;
      if (k == 1) start = 1'b0;
      if (poke && k == 2) begin
        start = 1'b1; length = 8'd3; seed = 10'h3AA;
      end
      if (poke && k == 3) start = 1'b0;
      if (go && finish) overlap = 1;
      if (go && go_cyc < 0) begin
        go_cyc = k; in_b = 1; mm_at_go = mismatch;
      end
      if (in_b) obs_q.push_back(data_out);
      if (finish) begin
        if (fin_cyc < 0) fin_cyc = k;
        in_b = 0;
      end
      if (done) begin
        done_cyc = k; mm = mismatch; er = exp_range;
      end
      if (k > 600) tmo = 1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; length = 8'd0; seed = '0; range_in = '0; error_in = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total_cnt++;
    if ({go, finish, busy, done, mismatch} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {go, finish, busy, done, mismatch});
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 10'd0) $display("FAIL reset_data got %0d want 0", data_out);
    else pass_cnt++;
    total_cnt++;
    if (exp_range !== 10'd0) $display("FAIL reset_exp_range got %0d want 0", exp_range);
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  // Pops the scoreboard against the recorded samples; one comparison per sample.
  task automatic test_samples_scoreboard(input string name);
    logic [9:0] e, o;
    total_cnt++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL %s_count got %0d want %0d", name, obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL %s_sample got %0d want %0d", name, o, e);
      else pass_cnt++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_basic(input string name, input logic [9:0] sd, input logic [7:0] len);
    int gc, fc, dc, n;
    logic mm, mg;
    logic [9:0] er, rng;
    bit ov, tmo;
    n = (len < 8'd2) ? 2 : int'(len);
    rng = model_burst(sd, len);
    drive_burst(sd, len, rng, 1'b0, 0, gc, fc, dc, mm, er, ov, mg, tmo);
    total_cnt++;
    if (tmo) $display("FAIL %s_timeout got no done want done", name);
    else pass_cnt++;
    total_cnt++;
    if (gc != 1 || fc != n || dc != n + 2)
      $display("FAIL %s_timing got go=%0d fin=%0d done=%0d want 1/%0d/%0d", name, gc, fc, dc, n, n + 2);
    else pass_cnt++;
    total_cnt++;
    if (ov) $display("FAIL %s_go_finish_overlap got 1 want 0", name);
    else pass_cnt++;
    total_cnt++;
    if (mm !== 1'b0 || er !== rng)
      $display("FAIL %s_result got mm=%b er=%0d want mm=0 er=%0d", name, mm, er, rng);
    else pass_cnt++;
    test_samples_scoreboard(name);
  endtask

  task automatic test_lfsr_len2;
`ifndef RSS_RAMP_MODE_EN
    int gc, fc, dc;
    logic mm, mg;
    logic [9:0] er;
    bit ov, tmo;
    drive_burst(10'd1, 8'd2, 10'd1, 1'b0, 0, gc, fc, dc, mm, er, ov, mg, tmo);
    total_cnt++;
    if (obs_q.size() != 2 || obs_q[0] !== 10'd1 || obs_q[1] !== 10'd2)
      $display("FAIL lfsr_len2_data got size %0d want data 1,2", obs_q.size());
    else pass_cnt++;
    total_cnt++;
    if (dc != 4 || mm !== 1'b0 || er !== 10'd1)
      $display("FAIL lfsr_len2_done got dc=%0d mm=%b er=%0d want 4/0/1", dc, mm, er);
    else pass_cnt++;
    obs_q.delete();
`endif
  endtask

  task automatic test_ramp;
`ifdef RSS_RAMP_MODE_EN
    int gc, fc, dc;
    logic mm, mg;
    logic [9:0] er;
    bit ov, tmo;
    drive_burst(10'd5, 8'd4, 10'd3, 1'b0, 0, gc, fc, dc, mm, er, ov, mg, tmo);
    total_cnt++;
    if (obs_q.size() != 4 || obs_q[0] !== 10'd5 || obs_q[3] !== 10'd8 || fc != 4 || er !== 10'd3 || mm !== 1'b0)
      $display("FAIL ramp_seed5 got fc=%0d er=%0d mm=%b want 4/3/0", fc, er, mm);
    else pass_cnt++;
    drive_burst(10'd1022, 8'd4, 10'd1023, 1'b0, 0, gc, fc, dc, mm, er, ov, mg, tmo);
    total_cnt++;
    if (obs_q.size() != 4 || obs_q[1] !== 10'd1023 || obs_q[2] !== 10'd0 || er !== 10'd1023 || mm !== 1'b0)
      $display("FAIL ramp_wrap got er=%0d mm=%b want 1023/0", er, mm);
    else pass_cnt++;
    obs_q.delete();
`endif
  endtask

  task automatic test_mismatch;
    int gc, fc, dc;
    logic mm, mg;
    logic [9:0] er, rng;
    bit ov, tmo;
    rng = model_burst(10'd1, 8'd2);
    exp_q.delete();
    drive_burst(10'd1, 8'd2, 10'd0, 1'b0, 0, gc, fc, dc, mm, er, ov, mg, tmo);
    total_cnt++;
    if (mm !== 1'b1 || er !== rng)
      $display("FAIL range_mismatch got mm=%b er=%0d want 1/%0d", mm, er, rng);
    else pass_cnt++;
    rng = model_burst(10'h0F3, 8'd5);
    exp_q.delete();
    drive_burst(10'h0F3, 8'd5, rng, 1'b1, 0, gc, fc, dc, mm, er, ov, mg, tmo);
    total_cnt++;
    if (mm !== 1'b1) $display("FAIL error_in_mismatch got %b want 1", mm);
    else pass_cnt++;
    obs_q.delete();
    error_in = 1'b0;
  endtask

  task automatic test_back_to_back;
    int gc, fc, dc;
    logic mm, mg;
    logic [9:0] er, rng;
    bit ov, tmo;
    drive_burst(10'd1, 8'd2, 10'd0, 1'b0, 0, gc, fc, dc, mm, er, ov, mg, tmo);
    // Next start is asserted in the done cycle of the failing burst.
    rng = model_burst(10'h155, 8'd3);
    drive_burst(10'h155, 8'd3, rng, 1'b0, 0, gc, fc, dc, mm, er, ov, mg, tmo);
    total_cnt++;
    if (gc != 1 || mg !== 1'b0)
      $display("FAIL back_to_back_start got go=%0d mm_at_go=%b want 1/0", gc, mg);
    else pass_cnt++;
    total_cnt++;
    if (dc != 5 || mm !== 1'b0 || er !== rng)
      $display("FAIL back_to_back_result got dc=%0d mm=%b er=%0d want 5/0/%0d", dc, mm, er, rng);
    else pass_cnt++;
    test_samples_scoreboard("back_to_back");
  endtask

  task automatic test_busy_start;
    int gc, fc, dc, extra_done, extra_busy;
    logic mm, mg;
    logic [9:0] er, rng;
    bit ov, tmo;
    rng = model_burst(10'h02A, 8'd6);
    drive_burst(10'h02A, 8'd6, rng, 1'b0, 1, gc, fc, dc, mm, er, ov, mg, tmo);
    extra_done = 0; extra_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    total_cnt++;
    if (dc != 8 || extra_done != 0 || extra_busy != 0)
      $display("FAIL busy_start_ignored got dc=%0d extra_done=%0d extra_busy=%0d want 8/0/0", dc, extra_done, extra_busy);
    else pass_cnt++;
    test_samples_scoreboard("busy_start");
  endtask

  task automatic test_reset_mid_stream;
    int dones;
    start = 1'b1; length = 8'd10; seed = 10'd1; range_in = '0; error_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      if (k == 1) start = 1'b0;
    end
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL mid_stream_busy_before got %b want 1", busy);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({go, finish, busy} !== 3'b000)
      $display("FAIL mid_stream_reset got %b want 000", {go, finish, busy});
    else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      if (done || busy) dones++;
    end
    total_cnt++;
    if (dones != 0) $display("FAIL mid_stream_no_done got %0d active cycles want 0", dones);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lfsr_len2();
    test_basic("len2", 10'd1, 8'd2);
    test_basic("len0", 10'd1, 8'd0);
    test_basic("len1_seed0", 10'd0, 8'd1);
    test_basic("len10", 10'h155, 8'd10);
    test_mismatch();
    test_back_to_back();
    test_busy_start();
    test_reset_mid_stream();
    test_basic("len255", 10'h2C7, 8'd255);
    test_ramp();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
